exec_dispatcher: RTL and testbench

- Sits directly downstream of the instruction launcher. Consumes its launched decoded_instr_t stream over valid/ready and routes each instruction to one of NFU functional units.
- Holds a one-entry output slot per unit and tracks per-unit outstanding operations with credit counters.
- Emits a same-cycle destination-register lock request to the regfile, so the launcher's lock view covers every dispatched instruction.

---
 rtl/exec_dispatcher.sv | 175 +++++++++++++++++
 tb/tb_exec_dispatcher.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_dispatcher.sv
// Execution dispatcher: routes launched instructions into one-entry per-unit
// output slots, tracks per-unit outstanding operations with credit counters,
// and raises a same-cycle destination-register lock request.

package maverickOne_pkg;

  localparam int NUM_REGS = 32;
  // The rd field sits directly above the 7-bit opcode.
  localparam int RD_LSB = 7;

  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } decoded_instr_t;

endpackage

module exec_dispatcher #(
  parameter int NFU     = 4,
  parameter int MAX_OUT = 2,
  parameter int DW      = $bits(maverickOne_pkg::decoded_instr_t),
  parameter int RW      = $clog2(maverickOne_pkg::NUM_REGS),
  // One bit wider than a unit index, so that out-of-range selects
  // (which are dropped and flagged) can actually be presented.
  parameter int SW      = $clog2(NFU) + 1
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic                   clear_i,
  input  logic [DW-1:0]          instr_in_i,
  input  logic [SW-1:0]          fu_sel_i,
  input  logic                   instr_in_valid_i,
  output logic                   instr_in_ready_o,
  output logic [NFU-1:0][DW-1:0] fu_instr_o,
  output logic [NFU-1:0]         fu_valid_o,
  input  logic [NFU-1:0]         fu_ready_i,
  input  logic [NFU-1:0]         fu_done_i,
  output logic                   lock_valid_o,
  output logic [RW-1:0]          lock_rd_o,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int IW = $clog2(NFU);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);
  localparam logic [SW-1:0] NFU_SEL = SW'(NFU);

  logic [RW-1:0]  in_rd;
  logic [IW-1:0]  sel_idx;
  logic           sel_ok;
  logic           accept;

  logic [NFU-1:0] drain;
  logic [NFU-1:0] free;
  logic [NFU-1:0] flush;
  logic [NFU-1:0] acc_vec;
  logic [NFU-1:0] under;

  logic [NFU-1:0] valid_q;
  logic [NFU-1:0] valid_d;
  logic [DW-1:0]  slot_q [NFU];
  logic [DW-1:0]  slot_d [NFU];
  logic [CW-1:0]  cnt_q  [NFU];
  logic [CW-1:0]  cnt_d  [NFU];
  logic [CW:0]    dec    [NFU];

  logic           err_q;
  logic           err_d;
  logic           busy_q;
  logic           busy_d;

  assign in_rd   = instr_in_i[maverickOne_pkg::RD_LSB +: RW];
  assign sel_idx = fu_sel_i[IW-1:0];
  assign sel_ok  = (fu_sel_i < NFU_SEL);

  // Input handshake, flush selection and lock request for the current cycle.
  always_comb begin
    drain = valid_q & fu_ready_i;
    free  = ~valid_q | drain;
    // A slot leaving through its own handshake in the clear cycle counts as
    // dispatched; only the ones still stuck are flushed.
    flush = clear_i ? (valid_q & ~drain) : '0;

    instr_in_ready_o = 1'b1;
    if (sel_ok) begin
      instr_in_ready_o = ~clear_i & free[sel_idx] & (cnt_q[sel_idx] < CNT_MAX);
    end

    accept  = instr_in_valid_i & instr_in_ready_o & sel_ok;
    acc_vec = '0;
    if (accept) begin
      acc_vec[sel_idx] = 1'b1;
    end

    lock_valid_o = accept & (in_rd != '0);
    lock_rd_o    = lock_valid_o ? in_rd : '0;
  end

  // Per-unit credit counters: +1 on accept, -1 per completion and per
  // flushed slot, saturating at zero with an underflow flag.
  always_comb begin
    under = '0;
    for (int f = 0; f < NFU; f++) begin
      dec[f]   = (CW+1)'(fu_done_i[f]) + (CW+1)'(flush[f]);
      cnt_d[f] = cnt_q[f];
      if (acc_vec[f]) begin
        // clear_i blocks acceptance, so only a completion can offset it.
        if (!fu_done_i[f]) begin
          cnt_d[f] = cnt_q[f] + CW'(1);
        end
      end else if (dec[f] > {1'b0, cnt_q[f]}) begin
        cnt_d[f] = '0;
        under[f] = 1'b1;
      end else begin
        cnt_d[f] = cnt_q[f] - dec[f][CW-1:0];
      end
    end
  end

  // Slot next state, busy summary and sticky error.
  always_comb begin
    valid_d = valid_q;
    busy_d  = 1'b0;
    for (int f = 0; f < NFU; f++) begin
      slot_d[f] = slot_q[f];
      if (acc_vec[f]) begin
        valid_d[f] = 1'b1;
        slot_d[f]  = instr_in_i;
      end else if (drain[f] | flush[f]) begin
        valid_d[f] = 1'b0;
      end
      if (valid_d[f] || (cnt_d[f] != '0)) begin
        busy_d = 1'b1;
      end
    end
    err_d = err_q | (instr_in_valid_i & ~sel_ok) | (|under);
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      valid_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      for (int f = 0; f < NFU; f++) begin
        slot_q[f] <= '0;
        cnt_q[f]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      for (int f = 0; f < NFU; f++) begin
        slot_q[f] <= slot_d[f];
        cnt_q[f]  <= cnt_d[f];
      end
    end
  end

  // Slot contents presented directly to the units.
  always_comb begin
    for (int f = 0; f < NFU; f++) begin
      fu_instr_o[f] = slot_q[f];
    end
  end

  assign fu_valid_o = valid_q;
  assign busy_o     = busy_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_exec_dispatcher.sv
// Self-checking bench for exec_dispatcher: directed scenarios followed by a
// randomized phase, all checked against a behavioural model of the slots,
// outstanding-op counts and error flag.

module tb_exec_dispatcher;
  import maverickOne_pkg::*;

  localparam int NFU     = 4;
  localparam int MAX_OUT = 2;
  localparam int DW      = $bits(decoded_instr_t);
  localparam int RW      = $clog2(NUM_REGS);
  localparam int SW      = $clog2(NFU) + 1;

  logic                   clk;
  logic                   srst;
  logic                   clear;
  logic [DW-1:0]          instr;
  logic [SW-1:0]          sel;
  logic                   valid;
  logic                   ready;
  logic [NFU-1:0][DW-1:0] fu_instr;
  logic [NFU-1:0]         fu_valid;
  logic [NFU-1:0]         fu_ready;
  logic [NFU-1:0]         fu_done;
  logic                   lock_valid;
  logic [RW-1:0]          lock_rd;
  logic                   busy;
  logic                   err;

  exec_dispatcher #(.NFU(NFU), .MAX_OUT(MAX_OUT)) dut (
    .clk_i            (clk),
    .srst_i           (srst),
    .clear_i          (clear),
    .instr_in_i       (instr),
    .fu_sel_i         (sel),
    .instr_in_valid_i (valid),
    .instr_in_ready_o (ready),
    .fu_instr_o       (fu_instr),
    .fu_valid_o       (fu_valid),
    .fu_ready_i       (fu_ready),
    .fu_done_i        (fu_done),
    .lock_valid_o     (lock_valid),
    .lock_rd_o        (lock_rd),
    .busy_o           (busy),
    .err_o            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model: what sits in each slot, how many ops each unit owes.
  bit            m_has  [NFU];
  logic [DW-1:0] m_data [NFU];
  int            m_cnt  [NFU];
  bit            m_err;
  bit            m_busy;

  function automatic logic [RW-1:0] rd_of(input logic [DW-1:0] x);
    decoded_instr_t d;
    d = x;
    return d.rd;
  endfunction

  function automatic logic [DW-1:0] mk(input int rd);
    decoded_instr_t d;
    d    = DW'({$urandom(), $urandom()});
    d.rd = rd[4:0];
    return d;
  endfunction

  function automatic bit m_ready();
    if (sel >= NFU) return 1'b1;
    return !clear && (!m_has[sel] || fu_ready[sel]) && (m_cnt[sel] < MAX_OUT);
  endfunction

  task automatic m_reset();
    for (int f = 0; f < NFU; f++) begin
      m_has[f]  = 1'b0;
      m_data[f] = '0;
      m_cnt[f]  = 0;
    end
    m_err  = 1'b0;
    m_busy = 1'b0;
  endtask

  task automatic set_idle();
    valid    = 1'b0;
    clear    = 1'b0;
    sel      = '0;
    instr    = '0;
    fu_ready = '1;
    fu_done  = '0;
  endtask

  task automatic do_reset();
    set_idle();
    srst = 1'b1;
    @(posedge clk);
    #1;
    srst = 1'b0;
    m_reset();
  endtask

  // One clock: compare DUT against the model, then advance the model.
  task automatic tick();
    bit             rdy;
    bit             acc;
    bit             lk;
    logic [NFU-1:0] vexp;
    #2;
    rdy = m_ready();
    acc = valid && rdy && (sel < NFU);
    lk  = acc && (rd_of(instr) != '0);
    if (!srst) begin
      chk("ready", ready, rdy);
      chk("lock_valid", lock_valid, lk);
      chk("lock_rd", lock_rd, lk ? rd_of(instr) : '0);
    end
    for (int f = 0; f < NFU; f++) vexp[f] = m_has[f];
    chk("fu_valid", fu_valid, vexp);
    for (int f = 0; f < NFU; f++) begin
      if (m_has[f]) chk($sformatf("payload%0d", f), fu_instr[f], m_data[f]);
    end
    chk("busy", busy, m_busy);
    chk("err", err, m_err);

    if (srst) begin
      m_reset();
    end else begin
      for (int f = 0; f < NFU; f++) begin
        bit drained = m_has[f] && fu_ready[f];
        bit flushed = clear && m_has[f] && !drained;
        bit took    = acc && (sel == f);
        int n;
        if (drained || flushed) m_has[f] = 1'b0;
        if (took) begin
          m_has[f]  = 1'b1;
          m_data[f] = instr;
        end
        n = m_cnt[f] + int'(took) - int'(fu_done[f]) - int'(flushed);
        if (n < 0) begin
          n     = 0;
          m_err = 1'b1;
        end
        m_cnt[f] = n;
      end
      if (valid && sel >= NFU) m_err = 1'b1;
      m_busy = 1'b0;
      for (int f = 0; f < NFU; f++) begin
        if (m_has[f] || m_cnt[f] != 0) m_busy = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] x_op;
  logic [DW-1:0] y_op;
  logic [DW-1:0] t_op;

  initial begin
    set_idle();
    srst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    srst = 1'b0;
    m_reset();

    // Reset state
    for (int f = 0; f < NFU; f++) chk($sformatf("rst_instr%0d", f), fu_instr[f], '0);
    chk("rst_ready", ready, 1);
    chk("rst_lock", lock_valid, 0);
    chk("rst_busy", busy, 0);
    tick();

    // Single op to unit 2, rd=5
    sel = 3'd2; instr = mk(5); valid = 1'b1;
    #1;
    chk("t_ready", ready, 1);
    chk("t_lock_valid", lock_valid, 1);
    chk("t_lock_rd", lock_rd, 5);
    t_op = instr;
    tick();
    valid = 1'b0;
    chk("t1_valid", fu_valid, 4'b0100);
    chk("t1_payload", fu_instr[2], t_op);
    tick();
    chk("t_busy_outstanding", busy, 1);
    fu_done = 4'b0100;
    tick();
    fu_done = '0;
    chk("t_busy_idle", busy, 0);
    tick();

    // Credit limit on unit 1
    do_reset();
    sel = 3'd1; valid = 1'b1;
    instr = mk(3); tick();
    instr = mk(4); tick();
    instr = mk(6);
    repeat (3) begin
      #1 chk("credit_hold_ready", ready, 0);
      tick();
    end
    fu_done = 4'b0010;
    tick();
    fu_done = '0;
    #1 chk("credit_release_ready", ready, 1);
    tick();
    valid = 1'b0;
    tick();

    // Stalled slot 0, unit 3 still served
    do_reset();
    fu_ready = 4'b1110;
    sel = 3'd0; valid = 1'b1; x_op = mk(7); instr = x_op;
    tick();
    y_op = mk(8); instr = y_op;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        sel = 3'd3; instr = mk(9);
        #1 chk("other_unit_ready", ready, 1);
        tick();
        sel = 3'd0; instr = y_op;
      end else begin
        #1;
        chk("stall_ready", ready, 0);
        chk("stall_payload", fu_instr[0], x_op);
        tick();
      end
    end

    // Same-cycle drain and accept on unit 0
    fu_ready = '1;
    #1 chk("drain_accept_ready", ready, 1);
    tick();
    valid = 1'b0;
    chk("nobubble_valid", fu_valid[0], 1);
    chk("nobubble_payload", fu_instr[0], y_op);
    chk("cnt0_full_ready", ready, 0);
    tick();

    // clear_i with slots 0 and 1 full, unit 1 draining
    do_reset();
    fu_ready = '0; valid = 1'b1;
    sel = 3'd0; instr = mk(1); tick();
    sel = 3'd1; instr = mk(2); tick();
    clear = 1'b1; fu_ready = 4'b0010; sel = 3'd2; instr = mk(3);
    #1 chk("clear_ready", ready, 0);
    tick();
    clear = 1'b0; valid = 1'b0; fu_ready = '1;
    chk("clear_slots", fu_valid, 4'b0000);
    chk("clear_busy", busy, 1);
    fu_done = 4'b0010;
    tick();
    fu_done = '0;
    chk("clear_cnt_settled", busy, 0);
    tick();

    // Out-of-range select
    do_reset();
    valid = 1'b1; sel = 3'd7; instr = mk(9);
    #1;
    chk("badsel_ready", ready, 1);
    chk("badsel_lock", lock_valid, 0);
    tick();
    valid = 1'b0;
    chk("badsel_err", err, 1);
    chk("badsel_noslot", fu_valid, 4'b0000);
    tick();

    // Completion with nothing outstanding, then reset mid-stall
    do_reset();
    fu_done = 4'b1000;
    tick();
    fu_done = '0;
    repeat (3) begin
      chk("done_underflow_err", err, 1);
      tick();
    end
    fu_ready = 4'b1110; valid = 1'b1; sel = 3'd0;
    instr = mk(2); tick();
    instr = mk(3); tick();
    srst = 1'b1;
    tick();
    srst = 1'b0; valid = 1'b0; fu_ready = '1;
    chk("srst_slots", fu_valid, 4'b0000);
    chk("srst_busy", busy, 0);
    chk("srst_err", err, 0);
    tick();

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      srst  = ($urandom_range(0, 299) == 0);
      clear = ($urandom_range(0, 31) == 0);
      valid = ($urandom_range(0, 9) < 7);
      sel   = ($urandom_range(0, 63) == 0) ? SW'($urandom_range(4, 7)) : SW'($urandom_range(0, 3));
      instr = mk($urandom_range(0, 31));
      fu_ready = NFU'($urandom());
      for (int f = 0; f < NFU; f++) begin
        if (m_cnt[f] > 0) fu_done[f] = ($urandom_range(0, 9) < 3);
        else              fu_done[f] = ($urandom_range(0, 499) == 0);
      end
      tick();
    end
    set_idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
